// File: rtl/i2c_target.sv
// I2C target: START/STOP detect, 7-bit address match, write RX and read TX.
// Optional SCL/SDA glitch filter enabled by defining `I2C_TGT_FILTER_EN.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h2A,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_IGNORE
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda;

  // two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TGT_FILTER_EN
  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

  logic          r_scl_f, r_sda_f;
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;

  // level follows the input only after FILTER_LEN equal samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
    end else begin
      if (r_scl_s2 == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == CMAX) begin
        r_scl_f   <= r_scl_s2;
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_s2 == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == CMAX) begin
        r_sda_f   <= r_sda_s2;
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  logic w_unused_flt;
  assign w_unused_flt = FILTER_LEN[0];
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  // previous levels for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = r_sda_d & ~w_sda & w_scl;
  assign w_stop     = ~r_sda_d & w_sda & w_scl;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_done, w_done_nxt;
  logic       r_sda_low, w_low_nxt;
  logic [7:0] r_rx_data, w_rx_nxt;
  logic       r_rx_valid, w_rxv_nxt;
  logic       r_tx_req, w_txr_nxt;
  logic       r_addr_hit, w_hit_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_busy, w_busy_nxt;
  logic [7:0] w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  // protocol state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_sda_low  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_addr_hit <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_done     <= w_done_nxt;
      r_sda_low  <= w_low_nxt;
      r_rx_data  <= w_rx_nxt;
      r_rx_valid <= w_rxv_nxt;
      r_tx_req   <= w_txr_nxt;
      r_addr_hit <= w_hit_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // next state: bus events win over bit sampling
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_done_nxt  = r_done;
    w_low_nxt   = r_sda_low;
    w_rx_nxt    = r_rx_data;
    w_rxv_nxt   = 1'b0;
    w_txr_nxt   = 1'b0;
    w_hit_nxt   = 1'b0;
    w_rw_nxt    = r_rw;
    w_busy_nxt  = r_busy;
    unique case (1'b1)
      w_start: begin
        w_state_nxt = S_ADDR;
        w_cnt_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_low_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
      w_stop: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_low_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        unique case (r_state)
          S_IDLE, S_IGNORE: begin
            w_low_nxt = 1'b0;
          end
          S_ADDR: begin
            if (w_scl_rise && !r_done) begin
              w_shift_nxt = w_byte;
              if (r_bit_cnt == 3'd7) begin
                if (w_byte[7:1] == DEV_ADDR) begin
                  w_done_nxt = 1'b1;
                  w_rw_nxt   = w_byte[0];
                  w_hit_nxt  = 1'b1;
                  w_busy_nxt = 1'b1;
                end else begin
                  w_state_nxt = S_IGNORE;
                end
              end else begin
                w_cnt_nxt = r_bit_cnt + 3'd1;
              end
            end else if (w_scl_fall && r_done) begin
              w_state_nxt = S_ADDR_ACK;
              w_low_nxt   = 1'b1;
              w_done_nxt  = 1'b0;
              w_cnt_nxt   = '0;
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              w_cnt_nxt = '0;
              if (r_rw) begin
                w_state_nxt = S_TX;
                w_shift_nxt = tx_data;
                w_low_nxt   = ~tx_data[7];
                w_txr_nxt   = 1'b1;
              end else begin
                w_state_nxt = S_RX;
                w_low_nxt   = 1'b0;
              end
            end
          end
          S_RX: begin
            if (w_scl_rise && !r_done) begin
              w_shift_nxt = w_byte;
              if (r_bit_cnt == 3'd7) begin
                w_rx_nxt   = w_byte;
                w_rxv_nxt  = 1'b1;
                w_done_nxt = 1'b1;
              end else begin
                w_cnt_nxt = r_bit_cnt + 3'd1;
              end
            end else if (w_scl_fall && r_done) begin
              w_state_nxt = S_RX_ACK;
              w_low_nxt   = 1'b1;
              w_done_nxt  = 1'b0;
              w_cnt_nxt   = '0;
            end
          end
          S_RX_ACK: begin
            if (w_scl_fall) begin
              w_state_nxt = S_RX;
              w_low_nxt   = 1'b0;
            end
          end
          S_TX: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd7) begin
                w_state_nxt = S_TX_ACK;
                w_low_nxt   = 1'b0;
                w_done_nxt  = 1'b0;
              end else begin
                w_shift_nxt = {r_shift[6:0], 1'b0};
                w_low_nxt   = ~r_shift[6];
                w_cnt_nxt   = r_bit_cnt + 3'd1;
              end
            end
          end
          S_TX_ACK: begin
            if (w_scl_rise && !r_done) begin
              if (!w_sda) w_done_nxt = 1'b1;
              else w_state_nxt = S_IGNORE;
            end else if (w_scl_fall && r_done) begin
              w_state_nxt = S_TX;
              w_shift_nxt = tx_data;
              w_low_nxt   = ~tx_data[7];
              w_txr_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_done_nxt  = 1'b0;
            end
          end
        endcase
      end
    endcase
  end

  assign sda      = r_sda_low ? 1'b0 : 1'bz;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign addr_hit = r_addr_hit;
  assign rw       = r_rw;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus master tasks, transfer-level model queues,
// per-cycle pulse checker and directed transactions.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_hit, rw, busy;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_target dut (
    .clk(clk),
    .rst(rst),
    .scl(scl),
    .sda(sda),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_req(tx_req),
    .addr_hit(addr_hit),
    .rw(rw),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_rx[$];
  logic       q_rw[$];
  int         exp_txr = 0;
  int         act_txr = 0;
  int         dut_low = 0;
  logic       prv_rxv = 1'b0;
  logic       prv_txr = 1'b0;
  logic       prv_hit = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // per-cycle check of the output pulses against the expected transfers
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rx_valid) begin
        logic [8:0] e;
        e = (q_rx.size() != 0) ? {1'b0, q_rx.pop_front()} : 9'h100;
        chk("rx_byte", {24'd0, 1'b0, rx_data}, {23'd0, e});
        chk("rxv_width", {31'd0, prv_rxv}, 32'd0);
      end
      if (addr_hit) begin
        logic [1:0] e;
        e = (q_rw.size() != 0) ? {1'b0, q_rw.pop_front()} : 2'b10;
        chk("hit_rw", {30'd0, 1'b0, rw}, {30'd0, e});
        chk("hit_busy", {31'd0, busy}, 32'd1);
        chk("hit_width", {31'd0, prv_hit}, 32'd0);
      end
      if (tx_req) begin
        act_txr++;
        chk("txr_width", {31'd0, prv_txr}, 32'd0);
      end
      if (!m_low && sda === 1'b0) dut_low++;
    end
    prv_rxv = rx_valid;
    prv_txr = tx_req;
    prv_hit = addr_hit;
  end

  task automatic bit_io(input logic b, output logic s);
    m_low = ~b;
    #50 scl = 1'b1;
    #50 s = sda;
    #50 scl = 1'b0;
    #50;
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    #50 scl = 1'b1;
    #50 m_low = 1'b1;
    #50 scl = 1'b0;
    #50;
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    #50 scl = 1'b1;
    #50 m_low = 1'b0;
    #100;
  endtask

  task automatic write_byte(input string nm, input logic [7:0] b,
                            output logic ack);
    logic [7:0] echo;
    for (int i = 7; i >= 0; i--) bit_io(b[i], echo[i]);
    bit_io(1'b1, ack);
    chk({nm, "_echo"}, {24'd0, echo}, {24'd0, b});
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack,
                           input logic [7:0] nxt);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(1'b1, d[i]);
    tx_data = nxt;
    bit_io(~mack, s);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({nm, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({nm, "_tx_req"}, {31'd0, tx_req}, 32'd0);
    chk({nm, "_addr_hit"}, {31'd0, addr_hit}, 32'd0);
    chk({nm, "_rw"}, {31'd0, rw}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_sda"}, {31'd0, sda}, 32'd1);
  endtask

  task automatic check_drained(input string nm);
    chk({nm, "_rx_left"}, q_rx.size(), 32'd0);
    chk({nm, "_rw_left"}, q_rw.size(), 32'd0);
    chk({nm, "_txr_cnt"}, act_txr, exp_txr);
    chk({nm, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({nm, "_sda_end"}, {31'd0, sda}, 32'd1);
  endtask

  initial begin
    logic       a, s;
    logic [7:0] d;
    int         low0;
    rst = 1'b1;
    scl = 1'b1;
    m_low = 1'b0;
    tx_data = 8'h00;
    #22;
    check_idle("reset");
    rst = 1'b0;
    #100;

    // write 0x2A,W then 0xC3
    q_rw.push_back(1'b0);
    q_rx.push_back(8'hC3);
    bus_start();
    write_byte("w_addr", 8'h54, a);
    chk("w_addr_ack", {31'd0, a}, 32'd0);
    chk("w_busy", {31'd0, busy}, 32'd1);
    write_byte("w_data", 8'hC3, a);
    chk("w_data_ack", {31'd0, a}, 32'd0);
    chk("w_rx_data", {24'd0, rx_data}, 32'h0000_00C3);
    bus_stop();
    check_drained("w");

    // address 0x15,W is not ours
    low0 = dut_low;
    bus_start();
    write_byte("n_addr", 8'h2A, a);
    chk("n_addr_nack", {31'd0, a}, 32'd1);
    write_byte("n_data", 8'h54, a);
    chk("n_data_nack", {31'd0, a}, 32'd1);
    bus_stop();
    chk("n_no_drive", dut_low - low0, 32'd0);
    check_drained("n");

    // read 0x2A,R returning 0xA5, initiator ACK then STOP
    tx_data = 8'hA5;
    q_rw.push_back(1'b1);
    exp_txr += 2;
    bus_start();
    write_byte("r1_addr", 8'h55, a);
    chk("r1_addr_ack", {31'd0, a}, 32'd0);
    read_byte(d, 1'b1, 8'hFF);
    chk("r1_byte", {24'd0, d}, 32'h0000_00A5);
    bus_stop();
    check_drained("r1");

    // two-byte read: 0xA5 ACKed, 0x3C NACKed
    tx_data = 8'hA5;
    q_rw.push_back(1'b1);
    exp_txr += 2;
    bus_start();
    write_byte("r2_addr", 8'h55, a);
    chk("r2_addr_ack", {31'd0, a}, 32'd0);
    read_byte(d, 1'b1, 8'h3C);
    chk("r2_byte0", {24'd0, d}, 32'h0000_00A5);
    read_byte(d, 1'b0, 8'h00);
    chk("r2_byte1", {24'd0, d}, 32'h0000_003C);
    chk("r2_released", {31'd0, sda}, 32'd1);
    bus_stop();
    check_drained("r2");

    // repeated START four bits into a write byte, then a read
    tx_data = 8'h96;
    q_rw.push_back(1'b0);
    q_rw.push_back(1'b1);
    exp_txr += 1;
    bus_start();
    write_byte("rs_addr", 8'h54, a);
    chk("rs_addr_ack", {31'd0, a}, 32'd0);
    bit_io(1'b1, s);
    bit_io(1'b0, s);
    bit_io(1'b1, s);
    bit_io(1'b0, s);
    bus_start();
    write_byte("rs_raddr", 8'h55, a);
    chk("rs_raddr_ack", {31'd0, a}, 32'd0);
    chk("rs_rw", {31'd0, rw}, 32'd1);
    read_byte(d, 1'b0, 8'h00);
    chk("rs_byte", {24'd0, d}, 32'h0000_0096);
    bus_stop();
    check_drained("rs");

    // reset while the address ACK is being driven
    q_rw.push_back(1'b0);
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'h54;
      bit_io(ab[i], s);
    end
    m_low = 1'b0;
    #50 scl = 1'b1;
    #50;
    chk("rst_ack_low", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    #49 rst = 1'b0;
    #50 scl = 1'b0;
    #50;
    low0 = dut_low;
    write_byte("rst_ign", 8'h54, a);
    chk("rst_ign_nack", {31'd0, a}, 32'd1);
    bus_stop();
    chk("rst_no_drive", dut_low - low0, 32'd0);
    check_drained("rst");

    // recovery after reset
    q_rw.push_back(1'b0);
    q_rx.push_back(8'h5A);
    bus_start();
    write_byte("rc_addr", 8'h54, a);
    chk("rc_addr_ack", {31'd0, a}, 32'd0);
    write_byte("rc_data", 8'h5A, a);
    chk("rc_data_ack", {31'd0, a}, 32'd0);
    chk("rc_rx_data", {24'd0, rx_data}, 32'h0000_005A);
    bus_stop();
    check_drained("rc");

    #100;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
